cic_interp: RTL and testbench

- 5-stage CIC interpolator, the transmit-side counterpart of the CIC decimator.
- Accepts low-rate signed samples over a valid/ready handshake and emits INTERP output samples per input sample on a fixed output cadence.
- Sits between the baseband/audio source and the DAC/upconversion path.
- Architecture: comb section at the input rate, zero-stuffing, integrator section at the output rate, variable-gain shift with saturation.

---
 rtl/cic_pkg.sv | 41 ++++
 rtl/cic_interp_ctrl.sv | 111 +++++++++++
 rtl/cic_interp.sv | 127 ++++++++++++
 tb/tb_cic_interp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_pkg
// Description : Shared constants, state type and saturation helper for the
//               CIC interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_pkg;

  // Order of the filter: number of comb stages and of integrator stages
  localparam int NUM_STAGES = 5;

  // Working width of the saturation helper; any WIDTH up to this is supported
  localparam int SAT_W = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clamp a signed value into the signed range of a 'bits'-wide word.
  // The caller truncates the result to 'bits'.
  function automatic logic signed [SAT_W-1:0] sat_trunc(
    input logic signed [SAT_W-1:0] value,
    input int                      bits
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) <<< (bits - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_interp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cic_interp_ctrl
// Description : Control path of the CIC interpolator: output-rate divider,
//               interpolation phase counter, one-entry input buffer with
//               valid/ready handshake, sticky underrun flag and IDLE/RUN FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interp_ctrl
  import cic_pkg::*;
#(
  parameter int INTERP  = 512,
  parameter int OUT_DIV = 1,
  parameter int BITS    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [BITS-1:0] x_in_i,
  input  logic                   in_valid_i,
  input  logic                   clr_underrun_i,
  output logic                   in_ready_o,
  output logic                   strobe_o,
  output logic                   consume_o,
  output logic signed [BITS-1:0] sample_o,
  output logic                   underrun_o
);

  localparam int DIV_W = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam int PH_W  = $clog2(INTERP);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OUT_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(INTERP - 1);

  state_e                 state_q;
  logic [DIV_W-1:0]       div_q;
  logic [PH_W-1:0]        ph_q;
  logic                   buf_full_q;
  logic signed [BITS-1:0] buf_q;
  logic                   underrun_q;

  logic strobe;
  logic consume;
  logic accept;

  // Derive output strobe, consume event, handshake and the comb-input sample
  always_comb begin
    strobe   = (state_q == RUN) && (div_q == DIV_LAST);
    consume  = strobe && (ph_q == '0);
    accept   = in_valid_i && !buf_full_q;
    sample_o = '0;
    if (buf_full_q) begin
      sample_o = buf_q;
    end else if (in_valid_i) begin
      // Empty buffer at a consume event: the offered sample bypasses the buffer
      sample_o = x_in_i;
    end
  end

  // FSM, divider, phase counter, input buffer and sticky underrun flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      ph_q       <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= RUN;
            div_q      <= '0;
            ph_q       <= '0;
            buf_q      <= x_in_i;
            buf_full_q <= 1'b1;
          end
        end
        RUN: begin
          if (strobe) begin
            div_q <= '0;
            ph_q  <= (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
          // A bypassed sample at a consume event is used directly, never stored
          if (consume && buf_full_q) begin
            buf_full_q <= 1'b0;
          end else if (accept && !consume) begin
            buf_q      <= x_in_i;
            buf_full_q <= 1'b1;
          end
          // A fresh underrun takes priority over a simultaneous clear
          if (consume && !buf_full_q && !in_valid_i) begin
            underrun_q <= 1'b1;
          end else if (clr_underrun_i) begin
            underrun_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o = !buf_full_q;
  assign strobe_o   = strobe;
  assign consume_o  = consume;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: rtl/cic_interp.sv
`default_nettype none
// ============================================================================
// Module      : cic_interp
// Description : 5-stage CIC interpolator. Combs run at the input rate,
//               zero-stuffing feeds the output-rate integrators, and the
//               result is scaled by a gain-controlled arithmetic shift with
//               saturation to BITS.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interp
  import cic_pkg::*;
#(
  parameter int WIDTH     = 56,
  parameter int INTERP    = 512,
  parameter int OUT_DIV   = 1,
  parameter int BITS      = 16,
  parameter int GAIN_BITS = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic signed [BITS-1:0] x_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [GAIN_BITS-1:0]   gain,
  output logic signed [BITS-1:0] x_out,
  output logic                   out_tick,
  output logic                   underrun,
  input  logic                   clr_underrun
);

  // Shift that brings full-scale integrator output back to BITS at gain 0
  localparam logic [31:0] SHIFT = 32'(WIDTH - BITS - 2);

  logic                    strobe;
  logic                    consume;
  logic signed [BITS-1:0]  sample;

  logic signed [WIDTH-1:0] comb_in;
  logic signed [WIDTH-1:0] comb_q  [NUM_STAGES];
  logic signed [WIDTH-1:0] dly_q   [NUM_STAGES];
  logic signed [WIDTH-1:0] integ_q [NUM_STAGES];

  logic [31:0]             gain_ext;
  logic [31:0]             sh_d;
  logic signed [WIDTH-1:0] shifted;
  logic signed [BITS-1:0]  x_out_d;

  logic signed [BITS-1:0]  x_out_q;
  logic                    out_tick_q;

  cic_interp_ctrl #(
    .INTERP  (INTERP),
    .OUT_DIV (OUT_DIV),
    .BITS    (BITS)
  ) u_ctrl (
    .clk_i          (CLK),
    .rst_i          (RST),
    .x_in_i         (x_in),
    .in_valid_i     (in_valid),
    .clr_underrun_i (clr_underrun),
    .in_ready_o     (in_ready),
    .strobe_o       (strobe),
    .consume_o      (consume),
    .sample_o       (sample),
    .underrun_o     (underrun)
  );

  // Sign-extend the consumed sample; selects zero when the buffer ran dry
  assign comb_in = WIDTH'(sample);

  // Comb chain, advancing once per consumed input sample
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        comb_q[k] <= '0;
        dly_q[k]  <= '0;
      end
    end else if (consume) begin
      comb_q[0] <= comb_in - dly_q[0];
      dly_q[0]  <= comb_in;
      for (int k = 1; k < NUM_STAGES; k++) begin
        comb_q[k] <= comb_q[k-1] - dly_q[k];
        dly_q[k]  <= comb_q[k-1];
      end
    end
  end

  // Integrator chain at the output rate; comb output enters only at phase 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_q[k] <= '0;
      end
    end else if (strobe) begin
      integ_q[0] <= integ_q[0] + (consume ? comb_q[NUM_STAGES-1] : '0);
      for (int k = 1; k < NUM_STAGES; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

  // Gain-controlled scaling: larger gain means a smaller right shift
  always_comb begin
    gain_ext = 32'(gain);
    sh_d     = (gain_ext >= SHIFT) ? 32'd0 : (SHIFT - gain_ext);
    shifted  = integ_q[NUM_STAGES-1] >>> sh_d;
    x_out_d  = BITS'(sat_trunc(SAT_W'(shifted), BITS));
  end

  // Registered output sample and its one-cycle update pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_out_q    <= '0;
      out_tick_q <= 1'b0;
    end else begin
      out_tick_q <= strobe;
      if (strobe) begin
        x_out_q <= x_out_d;
      end
    end
  end

  assign x_out    = x_out_q;
  assign out_tick = out_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_interp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cic_interp
// Description : Scoreboard bench for cic_interp. Two instances share CLK:
//               A (INTERP=4, OUT_DIV=1) and B (INTERP=4, OUT_DIV=3), both
//               WIDTH=32, BITS=16. Expected outputs are queued per instance
//               and compared by monitors on every out_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_interp;

  localparam int BITS      = 16;
  localparam int GAIN_BITS = 8;
  localparam int WIDTH     = 32;
  localparam int INTERP    = 4;

  typedef struct {
    bit chk;
    int val;
  } exp_t;

  // Impulse response for R=4, N=5: coefficients of (1+z+z^2+z^3)^5
  int H [16] = '{1, 5, 15, 35, 65, 101, 135, 155, 155, 135, 101, 65, 35, 15, 5, 1};

  exp_t q_a [$];
  exp_t q_b [$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   ticks_a = 0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                   rst_a = 1'b1, valid_a = 1'b0, clr_a = 1'b0;
  logic signed [BITS-1:0] x_a = '0;
  logic [GAIN_BITS-1:0]   gain_a = '0;
  logic                   ready_a, tick_a, ur_a;
  logic signed [BITS-1:0] xo_a;

  logic                   rst_b = 1'b1, valid_b = 1'b0, clr_b = 1'b0;
  logic signed [BITS-1:0] x_b = '0;
  logic [GAIN_BITS-1:0]   gain_b = '0;
  logic                   ready_b, tick_b, ur_b;
  logic signed [BITS-1:0] xo_b;

  cic_interp #(.WIDTH(WIDTH), .INTERP(INTERP), .OUT_DIV(1), .BITS(BITS), .GAIN_BITS(GAIN_BITS)) dut_a (
    .CLK(CLK), .RST(rst_a), .x_in(x_a), .in_valid(valid_a), .in_ready(ready_a), .gain(gain_a),
    .x_out(xo_a), .out_tick(tick_a), .underrun(ur_a), .clr_underrun(clr_a)
  );

  cic_interp #(.WIDTH(WIDTH), .INTERP(INTERP), .OUT_DIV(3), .BITS(BITS), .GAIN_BITS(GAIN_BITS)) dut_b (
    .CLK(CLK), .RST(rst_b), .x_in(x_b), .in_valid(valid_b), .in_ready(ready_b), .gain(gain_b),
    .x_out(xo_b), .out_tick(tick_b), .underrun(ur_b), .clr_underrun(clr_b)
  );

  // Monitor A: pop one expectation per output tick
  always @(negedge CLK) begin
    exp_t e;
    if (tick_a) begin
      ticks_a++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (int'(xo_a) != e.val) begin
            n_bad++;
            $display("FAIL scoreboard A: x_out=%0d required %0d at %0t", xo_a, e.val, $time);
          end
        end
      end
    end
  end

  // Monitor B
  always @(negedge CLK) begin
    exp_t e;
    if (tick_b) begin
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (int'(xo_b) != e.val) begin
            n_bad++;
            $display("FAIL scoreboard B: x_out=%0d required %0d at %0t", xo_b, e.val, $time);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input bit which, input bit chk, input int val);
    exp_t e;
    e.chk = chk;
    e.val = val;
    if (which) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  // 'pre' zero outputs, the 16-tap impulse response, then 4 trailing zeros
  task automatic push_imp(input bit which, input int pre);
    for (int i = 0; i < pre; i++) push(which, 1'b1, 0);
    for (int i = 0; i < 16; i++)  push(which, 1'b1, H[i]);
    for (int i = 0; i < 4; i++)   push(which, 1'b1, 0);
  endtask

  task automatic drain(input bit which, input string nm);
    int n = 0;
    while (((which ? q_b.size() : q_a.size()) != 0) && (n < 800)) begin
      @(negedge CLK);
      n++;
    end
    check({nm, " drained"}, which ? q_b.size() : q_a.size(), 0);
  endtask

  task automatic reset_dut(input bit which);
    @(negedge CLK);
    if (which) begin
      rst_b = 1'b1; valid_b = 1'b0; x_b = '0; clr_b = 1'b0;
    end else begin
      rst_a = 1'b1; valid_a = 1'b0; x_a = '0; clr_a = 1'b0;
    end
    repeat (2) @(negedge CLK);
    if (which) rst_b = 1'b0;
    else       rst_a = 1'b0;
  endtask

  // Constant input on A; outputs from index 40 onward are fully settled
  task automatic run_dc_a(input int g, input int x, input int req, input string nm);
    reset_dut(1'b0);
    gain_a = GAIN_BITS'(g);
    for (int i = 0; i < 40; i++) push(1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++)  push(1'b0, 1'b1, req);
    x_a     = BITS'(x);
    valid_a = 1'b1;
    drain(1'b0, nm);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge CLK);
    rst_a = 1'b0;
    rst_b = 1'b0;

    check("reset x_out A", xo_a, 0);
    check("reset out_tick A", tick_a, 0);
    check("reset underrun A", ur_a, 0);
    check("reset in_ready A", ready_a, 1);
    check("reset x_out B", xo_b, 0);
    check("reset in_ready B", ready_b, 1);

    // Impulse, sh=0: 25 zero outputs, then the impulse response
    gain_a = 8'd14;
    push_imp(1'b0, 25);
    x_a = 16'sd1; valid_a = 1'b1;
    @(negedge CLK);
    x_a = '0;
    drain(1'b0, "impulse A");

    // DC gain R^4=256 cancelled by sh=8
    run_dc_a(6, 1000, 1000, "dc +1000");

    // Asynchronous reset in the middle of a running stream
    @(negedge CLK);
    #2 rst_a = 1'b1;
    valid_a = 1'b0;
    #1;
    check("async reset x_out", xo_a, 0);
    check("async reset out_tick", tick_a, 0);
    check("async reset in_ready", ready_a, 1);
    @(negedge CLK);
    rst_a = 1'b0;
    t0 = ticks_a;
    repeat (20) @(negedge CLK);
    check("ticks while idle after reset", ticks_a - t0, 0);
    check("underrun idle after reset", ur_a, 0);

    run_dc_a(6, -1000, -1000, "dc -1000");
    run_dc_a(7, 20000, 32767, "sat positive");
    run_dc_a(7, -20000, -32768, "sat negative");
    run_dc_a(200, 1000, 32767, "gain clamp");

    // B: single impulse then no source; zeros are stuffed and underrun raised.
    // Accept at edge E0, consumes at E3, E15, E27, E39 (Nk = negedge before Ek).
    reset_dut(1'b1);
    gain_b = 8'd14;
    push_imp(1'b1, 25);
    x_b = 16'sd1; valid_b = 1'b1;          // N0
    @(negedge CLK);                        // N1
    valid_b = 1'b0; x_b = '0;
    check("B in_ready while full", ready_b, 0);
    repeat (3) @(negedge CLK);             // N4
    check("B in_ready after consume", ready_b, 1);
    repeat (11) @(negedge CLK);            // N15
    check("B underrun before miss", ur_b, 0);
    @(negedge CLK);                        // N16
    check("B underrun after miss", ur_b, 1);
    repeat (11) @(negedge CLK);            // N27
    clr_b = 1'b1;
    @(negedge CLK);                        // N28
    check("B underrun set beats clear", ur_b, 1);
    @(negedge CLK);                        // N29
    clr_b = 1'b0;
    check("B underrun cleared", ur_b, 0);
    repeat (11) @(negedge CLK);            // N40
    check("B underrun set again", ur_b, 1);
    drain(1'b1, "zero stuffing B");

    // B: bypass; impulse offered only during the consume edge E15 (strobe 4)
    reset_dut(1'b1);
    gain_b = 8'd14;
    push_imp(1'b1, 29);
    x_b = '0; valid_b = 1'b1;              // N0
    @(negedge CLK);                        // N1
    valid_b = 1'b0;
    repeat (14) @(negedge CLK);            // N15
    check("B ready before bypass", ready_b, 1);
    x_b = 16'sd1; valid_b = 1'b1;
    @(negedge CLK);                        // N16
    valid_b = 1'b0; x_b = '0;
    check("B underrun after bypass", ur_b, 0);
    check("B bypass not stored", ready_b, 1);
    drain(1'b1, "bypass B");

    // B: always-valid source keeps up; ready drops while the buffer is full
    reset_dut(1'b1);
    gain_b = 8'd6;
    for (int i = 0; i < 40; i++) push(1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++)  push(1'b1, 1'b1, 1000);
    x_b = 16'sd1000; valid_b = 1'b1;       // N0
    @(negedge CLK);                        // N1
    check("B handshake ready full", ready_b, 0);
    repeat (3) @(negedge CLK);             // N4
    check("B handshake ready freed", ready_b, 1);
    @(negedge CLK);                        // N5
    check("B handshake ready refilled", ready_b, 0);
    drain(1'b1, "handshake B");
    check("B handshake no underrun", ur_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
